// File: rtl/fir_coeff_ctrl_if.sv
// Coefficient load stream between a coefficient source (master) and fir_coeff_ctrl (slave).
interface fir_coeff_ctrl_if #(
    parameter int NB_COEFFS = 8
);
    logic                 i_load_start;
    logic [NB_COEFFS-1:0] i_coeff;
    logic                 i_coeff_valid;
    logic                 o_coeff_ready;

    modport master (
        output i_load_start,
        output i_coeff,
        output i_coeff_valid,
        input  o_coeff_ready
    );

    modport slave (
        input  i_load_start,
        input  i_coeff,
        input  i_coeff_valid,
        output o_coeff_ready
    );
endinterface

// File: rtl/fir_coeff_ctrl.sv
// Double-buffered FIR coefficient loader: fills a shadow bank over a ready/valid stream and
// swaps it into the active bank between samples. Option macro: FIR_COEFF_CHECKSUM_EN.
//
// state     | meaning
// IDLE      | active bank stable, waiting for i_load_start
// LOAD      | accepting tap words into the shadow bank, index 0..N_COEFFS-1
// CHECK     | (FIR_COEFF_CHECKSUM_EN only) accepting the modulo sum of the taps
// WAIT_SWAP | shadow complete, waiting for a cycle with no sample in flight
module fir_coeff_ctrl #(
    parameter int                              NB_COEFFS      = 8,
    parameter int                              N_COEFFS       = 8,
    parameter logic [NB_COEFFS*N_COEFFS-1:0]   DEFAULT_COEFFS = '0
) (
    input  logic                            i_clock,
    input  logic                            i_reset,
    fir_coeff_ctrl_if.slave                 load_if,
    input  logic                            i_sample_valid,
    output logic [NB_COEFFS*N_COEFFS-1:0]   o_coeffs,
    output logic                            o_busy,
    output logic                            o_swap,
    output logic                            o_load_err
);
    localparam int                IDX_W    = $clog2(N_COEFFS);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N_COEFFS - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD      = 2'd1,
`ifdef FIR_COEFF_CHECKSUM_EN
        CHECK     = 2'd3,
`endif
        WAIT_SWAP = 2'd2
    } state_t;

    state_t                            state;
    state_t                            state_next;
    logic [IDX_W-1:0]                  idx;
    logic [NB_COEFFS-1:0]              shadow [N_COEFFS];
    logic [NB_COEFFS*N_COEFFS-1:0]     shadow_flat;
    logic                              coeff_ready_q;
    logic                              ready_next;
    logic                              beat;
    logic                              wr_en;
    logic                              idx_clr;
    logic                              do_swap;
    logic                              err_set;

    assign beat                  = load_if.i_coeff_valid & coeff_ready_q;
    assign load_if.o_coeff_ready = coeff_ready_q;

`ifdef FIR_COEFF_CHECKSUM_EN
    logic [NB_COEFFS-1:0] shadow_sum;
    logic                 csum_ok;

    // In CHECK the shadow already holds every tap, so the sum can be taken straight from it.
    always_comb begin
        shadow_sum = '0;
        for (int k = 0; k < N_COEFFS; k++) begin
            shadow_sum = shadow_sum + shadow[k];
        end
        csum_ok = (load_if.i_coeff == shadow_sum);
    end
`endif

    always_comb begin
        shadow_flat = '0;
        for (int k = 0; k < N_COEFFS; k++) begin
            shadow_flat[k*NB_COEFFS +: NB_COEFFS] = shadow[k];
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (load_if.i_load_start) state_next = LOAD;
            end
            LOAD: begin
                if (!load_if.i_load_start && beat && (idx == LAST_IDX)) begin
`ifdef FIR_COEFF_CHECKSUM_EN
                    state_next = CHECK;
`else
                    state_next = WAIT_SWAP;
`endif
                end
            end
`ifdef FIR_COEFF_CHECKSUM_EN
            CHECK: begin
                if (beat) state_next = csum_ok ? WAIT_SWAP : IDLE;
            end
`endif
            WAIT_SWAP: begin
                if (!i_sample_valid) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        o_busy  = (state != IDLE);
`ifdef FIR_COEFF_CHECKSUM_EN
        ready_next = (state_next == LOAD) || (state_next == CHECK);
        err_set    = ((state == LOAD) && load_if.i_load_start) ||
                     ((state == CHECK) && beat && !csum_ok);
`else
        ready_next = (state_next == LOAD);
        err_set    = (state == LOAD) && load_if.i_load_start;
`endif
        // A restart in LOAD outranks a simultaneous beat: the word is dropped.
        wr_en   = (state == LOAD) && beat && !load_if.i_load_start;
        idx_clr = ((state == IDLE) || (state == LOAD)) && load_if.i_load_start;
        do_swap = (state == WAIT_SWAP) && !i_sample_valid;
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            idx           <= '0;
            coeff_ready_q <= 1'b0;
            o_swap        <= 1'b0;
            o_load_err    <= 1'b0;
            o_coeffs      <= DEFAULT_COEFFS;
            for (int k = 0; k < N_COEFFS; k++) begin
                shadow[k] <= '0;
            end
        end else begin
            coeff_ready_q <= ready_next;
            o_swap        <= do_swap;
            o_load_err    <= err_set;
            if (idx_clr) begin
                idx <= '0;
            end else if (wr_en) begin
                shadow[idx] <= load_if.i_coeff;
                idx         <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
            end
            if (do_swap) begin
                o_coeffs <= shadow_flat;
            end
        end
    end
endmodule

// File: tb/tb_fir_coeff_ctrl.sv
// Self-checking bench for fir_coeff_ctrl: directed and randomized loads compared against a
// bank-level reference model (whole-bank values, cycle arithmetic, pulse counts).
module tb_fir_coeff_ctrl;
    localparam int             NB  = 8;
    localparam int             N   = 8;
    localparam int             BW  = NB * N;
    localparam logic [BW-1:0]  DEF = 64'h1122_3344_5566_7788;
    localparam logic [BW-1:0]  SEQ_BANK = 64'h0807_0605_0403_0201;

    logic           i_clock = 1'b0;
    logic           i_reset;
    logic           i_sample_valid;
    logic [BW-1:0]  o_coeffs;
    logic           o_busy;
    logic           o_swap;
    logic           o_load_err;

    fir_coeff_ctrl_if #(.NB_COEFFS(NB)) load_if ();

    fir_coeff_ctrl #(
        .NB_COEFFS      (NB),
        .N_COEFFS       (N),
        .DEFAULT_COEFFS (DEF)
    ) dut (
        .i_clock        (i_clock),
        .i_reset        (i_reset),
        .load_if        (load_if),
        .i_sample_valid (i_sample_valid),
        .o_coeffs       (o_coeffs),
        .o_busy         (o_busy),
        .o_swap         (o_swap),
        .o_load_err     (o_load_err)
    );

    always #5 i_clock = ~i_clock;

    int            checks    = 0;
    int            errors    = 0;
    int            cyc       = 0;
    int            swap_cnt  = 0;
    int            err_cnt   = 0;
    int            exp_swaps = 0;
    int            exp_errs  = 0;
    logic [BW-1:0] bank_model;
`ifdef FIR_COEFF_CHECKSUM_EN
    bit            bad_csum  = 1'b0;
`endif

    always @(posedge i_clock) cyc <= cyc + 1;

    always @(negedge i_clock) begin
        if (o_swap === 1'b1)     swap_cnt++;
        if (o_load_err === 1'b1) err_cnt++;
    end

    task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clock);
        #1;
    endtask

    task automatic mid();
        @(negedge i_clock);
    endtask

    // Entered and left at posedge+1 of an idle cycle.
    task automatic run_load(input bit seq, input int abort_at, input int rst_at,
                            input int hold, input int gap_pct);
        logic [NB-1:0] w [N];
        logic [BW-1:0] new_bank;
        logic [NB-1:0] stale;
        int            k;
        int            t;
        int            n_load;
        int            extra;
        bit            err_exp;
        bit            restart;

        new_bank = '0;
        for (int i = 0; i < N; i++) begin
            w[i] = seq ? NB'(i + 1) : NB'($urandom);
            new_bank[i*NB +: NB] = w[i];
        end
        stale = (abort_at >= 0) ? '1 : '0;

        load_if.i_load_start  = 1'b1;
        load_if.i_coeff_valid = 1'($urandom);
        load_if.i_coeff       = NB'($urandom);
        i_sample_valid        = 1'($urandom);
        mid();
        t = cyc;
        check("idle_ready", load_if.o_coeff_ready, 0);
        check("idle_busy", o_busy, 0);
        tick();
        load_if.i_load_start = 1'b0;

        k = 0;
        n_load = 0;
        err_exp = 1'b0;
        while (k < N) begin
            n_load++;
            restart = 1'b0;
            i_sample_valid = 1'($urandom);
            if (k == rst_at) begin
                i_reset = 1'b1;
                load_if.i_coeff_valid = 1'b1;
                load_if.i_coeff = w[k];
                mid();
                tick();
                i_reset = 1'b0;
                load_if.i_coeff_valid = 1'b0;
                i_sample_valid = 1'b0;
                mid();
                check("rst_swap", o_swap, 0);
                check("rst_coeffs", o_coeffs, DEF);
                check("rst_busy", o_busy, 0);
                check("rst_ready", load_if.o_coeff_ready, 0);
                check("rst_err", o_load_err, 0);
                bank_model = DEF;
                tick();
                return;
            end
            if (k == abort_at) begin
                load_if.i_load_start  = 1'b1;
                load_if.i_coeff_valid = 1'b1;
                load_if.i_coeff       = ~w[0];
                abort_at = -1;
                stale    = '0;
                k        = 0;
                restart  = 1'b1;
                exp_errs++;
            end else if ($urandom_range(99) < gap_pct) begin
                load_if.i_coeff_valid = 1'b0;
                load_if.i_coeff       = NB'($urandom);
            end else begin
                load_if.i_coeff_valid = 1'b1;
                load_if.i_coeff       = w[k] ^ stale;
                k++;
            end
            mid();
            check("load_ready", load_if.o_coeff_ready, 1);
            check("load_busy", o_busy, 1);
            check("load_err", o_load_err, err_exp);
            check("load_swap", o_swap, 0);
            err_exp = restart;
            tick();
            load_if.i_load_start = 1'b0;
        end
        load_if.i_coeff_valid = 1'b0;
        extra = 0;

`ifdef FIR_COEFF_CHECKSUM_EN
        begin
            logic [NB-1:0] csum;
            csum = '0;
            for (int i = 0; i < N; i++) csum = csum + w[i];
            load_if.i_coeff_valid = 1'b1;
            load_if.i_coeff       = csum + NB'(bad_csum);
            i_sample_valid        = 1'($urandom);
            mid();
            check("chk_ready", load_if.o_coeff_ready, 1);
            check("chk_busy", o_busy, 1);
            tick();
            load_if.i_coeff_valid = 1'b0;
            extra = 1;
            if (bad_csum) begin
                exp_errs++;
                mid();
                check("csum_err", o_load_err, 1);
                check("csum_swap", o_swap, 0);
                check("csum_busy", o_busy, 0);
                check("csum_coeffs", o_coeffs, bank_model);
                tick();
                return;
            end
        end
`endif

        // Start and valid are both meaningless here and must be ignored.
        load_if.i_load_start  = 1'($urandom);
        load_if.i_coeff_valid = 1'($urandom);
        for (int h = 0; h < hold; h++) begin
            i_sample_valid = 1'b1;
            mid();
            check("hold_swap", o_swap, 0);
            check("hold_coeffs", o_coeffs, bank_model);
            check("hold_busy", o_busy, 1);
            check("hold_ready", load_if.o_coeff_ready, 0);
            check("hold_err", o_load_err, 0);
            tick();
        end
        i_sample_valid = 1'b0;
        mid();
        check("pre_swap", o_swap, 0);
        check("pre_coeffs", o_coeffs, bank_model);
        tick();
        load_if.i_load_start  = 1'b0;
        load_if.i_coeff_valid = 1'b0;
        mid();
        check("swap_pulse", o_swap, 1);
        check("swap_coeffs", o_coeffs, new_bank);
        check("swap_busy", o_busy, 0);
        check("swap_latency", BW'(cyc - t), BW'(n_load + hold + 2 + extra));
        bank_model = new_bank;
        exp_swaps++;
        tick();
        mid();
        check("swap_width", o_swap, 0);
        check("post_coeffs", o_coeffs, bank_model);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        i_reset               = 1'b1;
        i_sample_valid        = 1'b0;
        load_if.i_load_start  = 1'b0;
        load_if.i_coeff_valid = 1'b0;
        load_if.i_coeff       = '0;
        bank_model            = DEF;
        tick();
        tick();
        i_reset = 1'b0;
        mid();
        check("reset_coeffs", o_coeffs, DEF);
        check("reset_busy", o_busy, 0);
        check("reset_ready", load_if.o_coeff_ready, 0);
        check("reset_swap", o_swap, 0);
        check("reset_err", o_load_err, 0);
        tick();

        for (int i = 0; i < 20; i++) begin
            load_if.i_coeff_valid = 1'($urandom);
            load_if.i_coeff       = NB'($urandom);
            i_sample_valid        = 1'($urandom);
            tick();
        end
        load_if.i_coeff_valid = 1'b0;
        mid();
        check("idle_swaps", BW'(swap_cnt), 0);
        check("idle_coeffs", o_coeffs, DEF);
        check("idle_busy_end", o_busy, 0);
        tick();

        run_load(1'b1, -1, -1, 0, 0);
        check("seq_bank", o_coeffs, SEQ_BANK);

        run_load(1'b0, -1, -1, 5, 0);

        run_load(1'b1, 3, -1, 0, 0);
        check("abort_bank", o_coeffs, SEQ_BANK);

        run_load(1'b0, -1, 4, 0, 0);
        check("after_rst_bank", o_coeffs, DEF);
        run_load(1'b1, -1, -1, 0, 0);
        check("reload_bank", o_coeffs, SEQ_BANK);

        for (int r = 0; r < 10; r++) begin
            run_load(1'b0,
                     ($urandom_range(3) == 0) ? int'($urandom_range(N - 1)) : -1,
                     -1,
                     int'($urandom_range(4)),
                     30);
        end

`ifdef FIR_COEFF_CHECKSUM_EN
        bad_csum = 1'b1;
        run_load(1'b1, -1, -1, 0, 0);
        bad_csum = 1'b0;
        check("bad_csum_bank", o_coeffs, bank_model);
`endif

        mid();
        check("total_swaps", BW'(swap_cnt), BW'(exp_swaps));
        check("total_errs", BW'(err_cnt), BW'(exp_errs));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
